// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order instruction fetch queue between PC and decode
// Issues PC fetches to instruction memory, buffers in-order responses, drops wrong-path responses after flush.
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus_4
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_fill;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_drop_cnt;
  // Allocated-but-unfilled entries; disambiguates fill == tail when the queue is full.
  logic [CW-1:0]    r_pending;

  logic [CW:0] w_used;
  logic        w_can_issue;
  logic        w_accept;
  logic        w_rsp_drop;
  logic        w_rsp_fill;
  logic        w_deq;

  assign w_used      = {1'b0, r_count} + {1'b0, r_drop_cnt};
  assign w_can_issue = pc_valid && !flush && !reset && (w_used < DEPTH_W);
  assign w_accept    = w_can_issue && imem_req_ready;
  assign w_rsp_drop  = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_fill  = imem_rsp_valid && (r_drop_cnt == '0) && (r_pending != '0);
  assign w_deq       = instr_valid && instr_ready;

  assign imem_req_valid = w_can_issue;
  assign pc_ready       = w_accept;
  assign imem_req_addr  = {pc[31:2], 2'b00};

  assign instr_valid     = (r_count != '0) && r_filled[r_head];
  assign instr           = instr_valid ? r_data[r_head] : 32'h0;
  assign instr_pc        = instr_valid ? r_pc[r_head] : 32'h0;
  assign instr_pc_plus_4 = instr_valid ? (r_pc[r_head] + 32'd4) : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_drop_cnt <= '0;
      r_filled   <= '0;
    end else if (flush) begin
      // Unfilled entries become debts; a response landing this cycle settles one of them.
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pending  <= '0;
      r_filled   <= '0;
      r_drop_cnt <= r_drop_cnt + r_pending - CW'(w_rsp_drop || w_rsp_fill);
    end else begin
      if (w_accept) begin
        r_pc[r_tail]     <= pc;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + 1'b1;
      end
      if (w_rsp_fill) begin
        r_data[r_fill]   <= imem_rsp_data;
        r_filled[r_fill] <= 1'b1;
        r_fill           <= r_fill + 1'b1;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      r_count    <= r_count + CW'(w_accept) - CW'(w_deq);
      r_pending  <= r_pending + CW'(w_accept) - CW'(w_rsp_fill);
      r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
// In-order memory model plus scoreboard of expected {pc, word}; table vectors for the request path.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus_4;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .pc_ready        (pc_ready),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus_4 (instr_pc_plus_4)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct {
    logic [31:0] pc;
    logic        pc_valid;
    logic        req_ready;
    logic        flush;
    logic [31:0] exp_addr;
    logic        exp_req_valid;
    logic        exp_pc_ready;
  } vec_t;

  exp_t        sb[$];
  mem_t        mem_q[$];
  logic [31:0] pc_q[$];
  int          deq_cyc[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          acc_cnt = 0;
  bit          use_q = 1'b0;
  bit          rand_rdy = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_pc();
    if (use_q) begin
      pc_valid = (pc_q.size() > 0);
      pc       = (pc_q.size() > 0) ? pc_q[0] : 32'h0;
    end
  endtask

  // Observe at negedge what the coming posedge will commit, then advance the memory model.
  task automatic tick();
    logic        acc;
    logic        deq;
    logic [31:0] a;
    logic [31:0] tmp;
    exp_t        e;
    mem_t        m;
    int          due;
    @(negedge clk);
    acc = pc_valid && pc_ready;
    deq = instr_valid && instr_ready && !flush;
    if (deq) begin
      deq_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc 0x%08h with nothing expected", instr_pc);
      end else begin
        e = sb.pop_front();
        check("instr", instr, e.data);
        check("instr_pc", instr_pc, e.pc);
        check("instr_pc_plus_4", instr_pc_plus_4, e.pc + 32'd4);
      end
    end
    if (imem_rsp_valid && mem_q.size() > 0) m = mem_q.pop_front();
    if (flush) sb.delete();
    if (acc) begin
      a = {pc[31:2], 2'b00};
      check("imem_req_addr", imem_req_addr, a);
      acc_cnt++;
      sb.push_back('{pc, mem_word(a)});
      if (rand_rdy) lat = $urandom_range(1, 3);
      due = cyc + lat;
      if (mem_q.size() > 0 && mem_q[mem_q.size()-1].due >= due) due = mem_q[mem_q.size()-1].due + 1;
      mem_q.push_back('{a, due});
      if (use_q && pc_q.size() > 0) tmp = pc_q.pop_front();
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_q[0].addr);
      end
    end
    if (rand_rdy) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
    end
    drive_pc();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() > 0 || pc_q.size() > 0 || mem_q.size() > 0) && n < 400) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 400) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d entries still expected after %0d cycles", name, sb.size(), n);
    end
  endtask

  vec_t vecs[5];
  int   c0;

  initial begin
    reset = 1'b1; pc = 32'h1234; pc_valid = 1'b1; flush = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pc_ready", pc_ready, 0);
    check("reset_req_valid", imem_req_valid, 0);
    check("reset_instr_valid", instr_valid, 0);
    check("reset_instr", instr, 0);
    check("reset_instr_pc", instr_pc, 0);
    check("reset_pc_plus_4", instr_pc_plus_4, 0);
    reset = 1'b0; pc_valid = 1'b0;

    // Combinational request path.
    vecs[0] = '{32'h0000_0102, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b1};
    vecs[1] = '{32'h0000_0203, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0300, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0404, 1'b1, 1'b1, 1'b1, 32'h0000_0404, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      pc = vecs[i].pc; pc_valid = vecs[i].pc_valid;
      imem_req_ready = vecs[i].req_ready; flush = vecs[i].flush;
      #1;
      check("vec_req_addr", imem_req_addr, vecs[i].exp_addr);
      check("vec_req_valid", imem_req_valid, vecs[i].exp_req_valid);
      check("vec_pc_ready", pc_ready, vecs[i].exp_pc_ready);
      tick();
    end
    flush = 1'b0; pc_valid = 1'b0; imem_req_ready = 1'b1;
    drain("table");

    // Stream 0x0..0xC with 1-cycle memory: back-to-back delivery.
    use_q = 1'b1; lat = 1; deq_cyc.delete();
    pc_q = '{32'h0, 32'h4, 32'h8, 32'hC}; drive_pc();
    c0 = cyc;
    drain("stream");
    check("stream_count", deq_cyc.size(), 4);
    check("stream_first_latency", deq_cyc[0] - c0, 2);
    check("stream_back_to_back", deq_cyc[3] - deq_cyc[0], 3);

    // Backpressure: full at DEPTH, one dequeue frees exactly one slot.
    instr_ready = 1'b0; acc_cnt = 0;
    pc_q = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214}; drive_pc();
    repeat (10) tick();
    check("bp_accepts", acc_cnt, 4);
    check("bp_pc_ready_low", pc_ready, 0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (5) tick();
    check("bp_one_more", acc_cnt, 5);
    check("bp_still_full", pc_ready, 0);
    instr_ready = 1'b1;
    drain("backpressure");

    // Flush with two requests in flight on 3-cycle memory.
    lat = 3; deq_cyc.delete();
    pc_q = '{32'h10, 32'h14}; drive_pc();
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pc_q = '{32'h40}; drive_pc();
    drain("flush_inflight");
    check("flush_inflight_delivered", deq_cyc.size(), 1);

    // Flush coinciding with the only outstanding response.
    lat = 2; deq_cyc.delete();
    pc_q = '{32'h20}; drive_pc();
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; lat = 1;
    pc_q = '{32'h40}; drive_pc();
    drain("flush_with_rsp");
    check("flush_rsp_delivered", deq_cyc.size(), 1);

    // Steady state accept+fill+dequeue across pointer wrap, ending at the top of address space.
    lat = 1; deq_cyc.delete();
    for (int i = 0; i < 12; i++) pc_q.push_back(32'h1000 + 32'(i * 4));
    pc_q.push_back(32'hFFFF_FFFC);
    drive_pc();
    drain("wrap");
    check("wrap_count", deq_cyc.size(), 13);
    check("wrap_back_to_back", deq_cyc[12] - deq_cyc[0], 12);

    // Random handshakes and latencies.
    rand_rdy = 1'b1; deq_cyc.delete();
    for (int i = 0; i < 40; i++) pc_q.push_back($urandom());
    drive_pc();
    drain("random");
    check("random_count", deq_cyc.size(), 40);
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
